// File: rtl/timer_arbiter_if.sv
// Requester-side bundle for the shared down-counter timer.
// The master drives requests and lengths; the slave (arbiter) returns grant, completion and timer state.
interface timer_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IW    = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_len;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [IW-1:0]          owner;
  logic [WIDTH-1:0]       cnt;

  modport master (output req, req_len, input gnt, done, busy, owner, cnt);
  modport slave  (input req, req_len, output gnt, done, busy, owner, cnt);
endinterface

// File: rtl/timer_arbiter.sv
// Round-robin owner of one down-counter timer shared by N_REQ requesters.
// A grant loads the owner's length, counts to zero, then pulses done for one cycle.
module timer_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic           clk,
  input  logic           rst,
  timer_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [IW-1:0]    winner;
  logic [IW-1:0]    owner_nxt;
  logic             any_req;

  // Cyclic search from ptr; walking offsets high-to-low lets the nearest set bit win last.
  always_comb begin
    int idx;
    idx     = 0;
    winner  = '0;
    any_req = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (bus.req[idx]) begin
        winner  = IW'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign owner_nxt = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = done_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        gnt_d  = '0;
        done_d = '0;
        if (any_req) begin
          gnt_d   = N_REQ'(1) << winner;
          owner_d = winner;
          cnt_d   = bus.req_len[int'(winner)*WIDTH +: WIDTH];
          state_d = RUN;
        end else begin
          cnt_d = '0;
        end
      end
      RUN: begin
        // Abort outranks finish so a dropped request never sees a done pulse.
        if (!bus.req[owner_q]) begin
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = owner_nxt;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          gnt_d   = '0;
          done_d  = gnt_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        done_d  = '0;
        ptr_d   = owner_nxt;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        done_d  = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.owner = owner_q;
  assign bus.cnt   = cnt_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: directed scenarios then random requesters, checked
// against a timing-arithmetic reference model and an event scoreboard.
module tb_timer_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  timer_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus();
  timer_arbiter #(.N_REQ(N), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit is_done;
    int idx;
    int len;
    int cyc;
  } ev_t;

  ev_t q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;
  bit  rand_en = 1'b0;

  // Reference model: a grant at edge t0 with length L means RUN for edges t0+1..t0+L+1,
  // done shown after edge t0+L+1, idle again after edge t0+L+2.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_len   = 0;
  int m_t0    = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_proc();
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
      end else if (!m_busy) begin
        if (bus.req != '0) begin
          bit found;
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (!found && bus.req[i]) begin
              m_owner = i;
              found   = 1'b1;
            end
          end
          m_len  = int'(bus.req_len[m_owner*W +: W]);
          m_busy = 1'b1;
          m_t0   = cyc;
          q.push_back('{is_done: 1'b0, idx: m_owner, len: m_len, cyc: cyc});
        end
      end else begin
        int j;
        j = cyc - 1 - m_t0;
        if (j <= m_len) begin
          if (!bus.req[m_owner]) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % N;
          end else if (j == m_len) begin
            q.push_back('{is_done: 1'b1, idx: m_owner, len: 0, cyc: cyc});
          end
        end else begin
          m_busy = 1'b0;
          m_ptr  = (m_owner + 1) % N;
        end
      end
    end
  endtask

  task automatic monitor_proc();
    logic [N-1:0] pg;
    pg = '0;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        int  k;
        bit  in_run;
        bit  dut_g;
        ev_t e;
        k      = cyc - m_t0;
        in_run = m_busy && (k <= m_len);
        check("busy",  int'(bus.busy),  int'(m_busy));
        check("owner", int'(bus.owner), m_owner);
        check("cnt",   int'(bus.cnt),   in_run ? (m_len - k) : 0);
        dut_g = (bus.gnt != '0) && (pg == '0);
        if (q.size() > 0 && q[0].cyc == cyc) begin
          e = q.pop_front();
          if (!e.is_done) begin
            check("grant_event", int'(dut_g), 1);
            check("gnt_onehot",  int'(bus.gnt), 1 << e.idx);
            check("grant_cnt",   int'(bus.cnt), e.len);
          end else begin
            check("done_onehot", int'(bus.done), 1 << e.idx);
            check("gnt_in_done", int'(bus.gnt), 0);
          end
        end else begin
          check("spurious_grant", int'(dut_g), 0);
          check("spurious_done",  int'(bus.done), 0);
          check("gnt_hold", int'(bus.gnt), in_run ? (1 << m_owner) : 0);
        end
        pg = bus.gnt;
      end
    end
  endtask

  function automatic logic [W-1:0] rand_len();
    return ($urandom_range(0, 15) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 6));
  endfunction

  // One cycle of requester behaviour: drop on done, plus random traffic when enabled.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (bus.req[i] && bus.done[i]) bus.req[i] = 1'b0;
    if (rand_en) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < N; i++) begin
        if (bus.req[i] && bus.gnt[i] && $urandom_range(0, 29) == 0) bus.req[i] = 1'b0;
        else if (bus.gnt[i] && $urandom_range(0, 7) == 0) bus.req_len[i*W +: W] = rand_len();
        else if (!bus.req[i] && !bus.done[i] && $urandom_range(0, 3) == 0) begin
          bus.req[i] = 1'b1;
          bus.req_len[i*W +: W] = rand_len();
        end
      end
    end
  endtask

  task automatic set_len(int i, int len);
    bus.req_len[i*W +: W] = W'(len);
  endtask

  task automatic wait_cnt(int i, int val, string name);
    bit found;
    found = 1'b0;
    for (int t = 0; t < 400 && !found; t++) begin
      if (bus.gnt[i] && int'(bus.cnt) == val) found = 1'b1;
      else step();
    end
    check(name, int'(found), 1);
  endtask

  initial begin
    bus.req     = '0;
    bus.req_len = '0;
    fork
      model_proc();
      monitor_proc();
    join_none

    // Reset held with all requests high, then quiet idle.
    bus.req = '1;
    repeat (3) step();
    rst = 1'b0;
    bus.req = '0;
    repeat (5) step();

    // Single run, length 5 on requester 2.
    set_len(2, 5);
    bus.req[2] = 1'b1;
    repeat (12) step();

    // Round-robin fairness from a fresh pointer, two rounds.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_len(i, 1);
    bus.req = '1;
    repeat (25) step();
    bus.req = '1;
    repeat (25) step();

    // Zero length, then max length.
    set_len(1, 0);
    bus.req[1] = 1'b1;
    repeat (8) step();
    set_len(0, 255);
    bus.req[0] = 1'b1;
    repeat (265) step();

    // Abort of requester 3 with requester 0 pending.
    set_len(3, 10);
    bus.req[3] = 1'b1;
    step();
    set_len(0, 2);
    bus.req[0] = 1'b1;
    wait_cnt(3, 6, "wait_abort_cnt");
    bus.req[3] = 1'b0;
    repeat (10) step();

    // Reset in the middle of a run.
    set_len(1, 10);
    bus.req[1] = 1'b1;
    wait_cnt(1, 4, "wait_reset_cnt");
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (16) step();
    bus.req = '0;
    repeat (4) step();

    // Random traffic with occasional resets.
    rand_en = 1'b1;
    repeat (4000) step();
    rand_en = 1'b0;
    rst = 1'b0;
    bus.req = '0;
    repeat (20) step();
    check("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
